// File: rtl/ikbd_host_acia.sv
// ikbd_host_acia
// Host (Atari ST) side of the IKBD serial link. This is a subset of the
// MC6850 ACIA that exchanges 8N1 frames with the keyboard MCU's SCI at a
// fixed bit period of CLKS_PER_BIT clocks.
//
// Ports
//   CLKx2  : clock. All state changes on its rising edge.
//   RST    : synchronous reset, active-high.
//   cs     : register select enable.
//   rs     : register select. 0 = CR (write) / SR (read), 1 = TDR (write) / RDR (read).
//   wr     : write strobe, qualified by cs.
//   rd     : one-cycle read strobe. It only qualifies read side effects.
//   din    : write data.
//   dout   : read data. Combinational from rs: SR when rs=0, RDR when rs=1.
//   irq    : interrupt request, active-high.
//   rx     : serial input from the MCU tx pin (idles high).
//   tx     : registered serial output to the MCU rx pin (idles high).
//
// SR layout: {irq, 0, OVRN, FE, 0, 0, TDRE, RDRF}.
// CR[1:0] == 2'b11 is master reset. CR[6:5] == 2'b01 enables the transmit
// interrupt. CR[7] enables the receive interrupt.

module ikbd_host_acia #(
    parameter int CLKS_PER_BIT = 256
) (
    input  logic       CLKx2,
    input  logic       RST,
    input  logic       cs,
    input  logic       rs,
    input  logic       wr,
    input  logic       rd,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       irq,
    input  logic       rx,
    output logic       tx
);

    localparam int          SYNC_STAGES = 2;
    localparam logic [15:0] BIT_LAST    = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST   = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } ser_state_t;

    // Register file and status flags
    logic [7:0]  cr_reg,   cr_next;
    logic [7:0]  tdr_reg,  tdr_next;
    logic [7:0]  rdr_reg,  rdr_next;
    logic        rdrf_reg, rdrf_next;
    logic        tdre_reg, tdre_next;
    logic        fe_reg,   fe_next;
    logic        ovrn_reg, ovrn_next;

    // Transmitter
    ser_state_t  tx_state_reg, tx_state_next;
    logic [15:0] tx_cnt_reg,   tx_cnt_next;
    logic [7:0]  tx_shift_reg, tx_shift_next;
    logic [2:0]  tx_bit_reg,   tx_bit_next;
    logic        tx_reg,       tx_next;

    // Receiver
    logic [SYNC_STAGES-1:0] rx_pipe_reg;
    logic        rx_sync;
    logic        rx_prev_reg;
    ser_state_t  rx_state_reg, rx_state_next;
    logic [15:0] rx_cnt_reg,   rx_cnt_next;
    logic [7:0]  rx_shift_reg, rx_shift_next;
    logic [2:0]  rx_bit_reg,   rx_bit_next;

    logic master_rst;
    logic wr_cr;
    logic wr_tdr;
    logic rd_rdr;
    logic rx_fall;

    // CR[4:2] is the 6850 word-select field. The frame format here is
    // fixed at 8N1, so these bits are stored but have no effect.
    logic unused_cr_bits;
    assign unused_cr_bits = ^cr_reg[4:2];

    assign master_rst = (cr_reg[1:0] == 2'b11);
    assign wr_cr      = cs & wr & ~rs;
    assign wr_tdr     = cs & wr & rs;
    assign rd_rdr     = cs & rd & rs;

    // Two-stage rx synchroniser. Stage 0 takes the pin and each later
    // stage takes the one before it.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_rx_sync
            always_ff @(posedge CLKx2) begin
                if (RST) begin
                    rx_pipe_reg[gi] <= 1'b1;
                end else if (gi == 0) begin
                    rx_pipe_reg[gi] <= rx;
                end else begin
                    rx_pipe_reg[gi] <= rx_pipe_reg[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    assign rx_sync = rx_pipe_reg[SYNC_STAGES-1];
    assign rx_fall = rx_prev_reg & ~rx_sync;

    // State registers
    always_ff @(posedge CLKx2) begin
        if (RST) begin
            cr_reg       <= 8'h03;
            tdr_reg      <= 8'h00;
            rdr_reg      <= 8'h00;
            rdrf_reg     <= 1'b0;
            tdre_reg     <= 1'b0;
            fe_reg       <= 1'b0;
            ovrn_reg     <= 1'b0;
            tx_state_reg <= ST_IDLE;
            tx_cnt_reg   <= 16'd0;
            tx_shift_reg <= 8'h00;
            tx_bit_reg   <= 3'd0;
            tx_reg       <= 1'b1;
            rx_prev_reg  <= 1'b1;
            rx_state_reg <= ST_IDLE;
            rx_cnt_reg   <= 16'd0;
            rx_shift_reg <= 8'h00;
            rx_bit_reg   <= 3'd0;
        end else begin
            cr_reg       <= cr_next;
            tdr_reg      <= tdr_next;
            rdr_reg      <= rdr_next;
            rdrf_reg     <= rdrf_next;
            tdre_reg     <= tdre_next;
            fe_reg       <= fe_next;
            ovrn_reg     <= ovrn_next;
            tx_state_reg <= tx_state_next;
            tx_cnt_reg   <= tx_cnt_next;
            tx_shift_reg <= tx_shift_next;
            tx_bit_reg   <= tx_bit_next;
            tx_reg       <= tx_next;
            rx_prev_reg  <= rx_sync;
            rx_state_reg <= rx_state_next;
            rx_cnt_reg   <= rx_cnt_next;
            rx_shift_reg <= rx_shift_next;
            rx_bit_reg   <= rx_bit_next;
        end
    end

    // Next-state logic. The statements are ordered so that a later
    // assignment wins: a read clears the flags first, a completing frame
    // then sets them again, and master reset overrides everything except
    // the CR write itself.
    always_comb begin
        cr_next       = cr_reg;
        tdr_next      = tdr_reg;
        rdr_next      = rdr_reg;
        rdrf_next     = rdrf_reg;
        tdre_next     = tdre_reg;
        fe_next       = fe_reg;
        ovrn_next     = ovrn_reg;
        tx_state_next = tx_state_reg;
        tx_cnt_next   = tx_cnt_reg;
        tx_shift_next = tx_shift_reg;
        tx_bit_next   = tx_bit_reg;
        tx_next       = tx_reg;
        rx_state_next = rx_state_reg;
        rx_cnt_next   = rx_cnt_reg;
        rx_shift_next = rx_shift_reg;
        rx_bit_next   = rx_bit_reg;

        if (rd_rdr) begin
            rdrf_next = 1'b0;
            fe_next   = 1'b0;
            ovrn_next = 1'b0;
        end

        // Transmit FSM. The start bit is driven on the same edge that
        // consumes TDR, so each state spans exactly CLKS_PER_BIT clocks.
        case (tx_state_reg)
            ST_IDLE: begin
                if (!tdre_reg) begin
                    tx_shift_next = tdr_reg;
                    tdre_next     = 1'b1;
                    tx_next       = 1'b0;
                    tx_cnt_next   = 16'd0;
                    tx_state_next = ST_START;
                end
            end
            ST_START: begin
                if (tx_cnt_reg == BIT_LAST) begin
                    tx_cnt_next   = 16'd0;
                    tx_next       = tx_shift_reg[0];
                    tx_shift_next = {1'b0, tx_shift_reg[7:1]};
                    tx_bit_next   = 3'd0;
                    tx_state_next = ST_DATA;
                end else begin
                    tx_cnt_next = tx_cnt_reg + 16'd1;
                end
            end
            ST_DATA: begin
                if (tx_cnt_reg == BIT_LAST) begin
                    tx_cnt_next = 16'd0;
                    if (tx_bit_reg == 3'd7) begin
                        tx_next       = 1'b1;
                        tx_state_next = ST_STOP;
                    end else begin
                        tx_next       = tx_shift_reg[0];
                        tx_shift_next = {1'b0, tx_shift_reg[7:1]};
                        tx_bit_next   = tx_bit_reg + 3'd1;
                    end
                end else begin
                    tx_cnt_next = tx_cnt_reg + 16'd1;
                end
            end
            ST_STOP: begin
                if (tx_cnt_reg == BIT_LAST) begin
                    tx_cnt_next = 16'd0;
                    if (!tdre_reg) begin
                        // Pending byte: the next start bit follows the stop
                        // bit with no idle gap.
                        tx_shift_next = tdr_reg;
                        tdre_next     = 1'b1;
                        tx_next       = 1'b0;
                        tx_state_next = ST_START;
                    end else begin
                        tx_state_next = ST_IDLE;
                    end
                end else begin
                    tx_cnt_next = tx_cnt_reg + 16'd1;
                end
            end
            default: tx_state_next = ST_IDLE;
        endcase

        // A TDR write on the load edge leaves the new byte pending. The
        // byte that was just loaded is the old one.
        if (wr_tdr) begin
            tdr_next  = din;
            tdre_next = 1'b0;
        end

        // Receive FSM. Check the start bit at mid-bit, then sample each bit
        // one bit period apart.
        case (rx_state_reg)
            ST_IDLE: begin
                if (rx_fall) begin
                    rx_cnt_next   = 16'd0;
                    rx_state_next = ST_START;
                end
            end
            ST_START: begin
                if (rx_cnt_reg == HALF_LAST) begin
                    rx_cnt_next = 16'd0;
                    if (rx_sync) begin
                        rx_state_next = ST_IDLE;  // glitch, not a start bit
                    end else begin
                        rx_bit_next   = 3'd0;
                        rx_state_next = ST_DATA;
                    end
                end else begin
                    rx_cnt_next = rx_cnt_reg + 16'd1;
                end
            end
            ST_DATA: begin
                if (rx_cnt_reg == BIT_LAST) begin
                    rx_cnt_next   = 16'd0;
                    rx_shift_next = {rx_sync, rx_shift_reg[7:1]};
                    if (rx_bit_reg == 3'd7) begin
                        rx_state_next = ST_STOP;
                    end else begin
                        rx_bit_next = rx_bit_reg + 3'd1;
                    end
                end else begin
                    rx_cnt_next = rx_cnt_reg + 16'd1;
                end
            end
            ST_STOP: begin
                if (rx_cnt_reg == BIT_LAST) begin
                    rx_cnt_next   = 16'd0;
                    rx_state_next = ST_IDLE;
                    // A read on this same edge frees RDR for the new byte.
                    if (rdrf_reg && !rd_rdr) begin
                        ovrn_next = 1'b1;
                    end else begin
                        rdr_next  = rx_shift_reg;
                        rdrf_next = 1'b1;
                    end
                    if (!rx_sync) begin
                        fe_next = 1'b1;
                    end
                end else begin
                    rx_cnt_next = rx_cnt_reg + 16'd1;
                end
            end
            default: rx_state_next = ST_IDLE;
        endcase

        if (master_rst) begin
            tdr_next      = tdr_reg;  // TDR writes are ignored
            rdrf_next     = 1'b0;
            tdre_next     = 1'b0;
            fe_next       = 1'b0;
            ovrn_next     = 1'b0;
            tx_state_next = ST_IDLE;
            tx_cnt_next   = 16'd0;
            tx_bit_next   = 3'd0;
            tx_next       = 1'b1;
            rx_state_next = ST_IDLE;
            rx_cnt_next   = 16'd0;
            rx_bit_next   = 3'd0;
        end

        if (wr_cr) begin
            cr_next = din;
            // Leaving master reset makes the transmitter ready.
            if (master_rst && (din[1:0] != 2'b11)) begin
                tdre_next = 1'b1;
            end
        end
    end

    assign irq  = ~master_rst &
                  ((cr_reg[7] & (rdrf_reg | ovrn_reg)) |
                   ((cr_reg[6:5] == 2'b01) & tdre_reg));
    assign dout = rs ? rdr_reg
                     : {irq, 1'b0, ovrn_reg, fe_reg, 2'b00, tdre_reg, rdrf_reg};
    assign tx   = tx_reg;

endmodule

// File: tb/tb_ikbd_host_acia.sv
// Self-checking bench for ikbd_host_acia. Transmitted bytes are queued when
// TDR is written and checked by a line monitor. Received bytes are queued
// when a frame is driven on rx and checked when RDR is read.

module tb_ikbd_host_acia;

    localparam int CPB   = 256;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       srst = 1'b1;
    logic       cs = 1'b0;
    logic       rs = 1'b0;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       irq;
    logic       rx = 1'b1;
    logic       tx;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] exp_tx_q[$];
    logic [7:0] exp_rx_q[$];
    int         tx_fall_q[$];
    bit         mon_busy   = 1'b0;
    bit         mon_ignore = 1'b0;

    ikbd_host_acia #(.CLKS_PER_BIT(CPB)) dut (
        .CLKx2 (clk),
        .RST   (srst),
        .cs    (cs),
        .rs    (rs),
        .wr    (wr),
        .rd    (rd),
        .din   (din),
        .dout  (dout),
        .irq   (irq),
        .rx    (rx),
        .tx    (tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic r, input logic [7:0] d);
        cs = 1'b1; wr = 1'b1; rs = r; din = d;
        tick();
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic read_reg(input logic r, output logic [7:0] d);
        cs = 1'b1; rd = 1'b1; rs = r;
        #1 d = dout;
        tick();
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) tick();
        end
        rx = stop;
        repeat (CPB) tick();
        rx = 1'b1;
        repeat (16) tick();
    endtask

    task automatic wait_falls(input int n);
        for (int i = 0; i < 4000 && tx_fall_q.size() < n; i++) tick();
        check("tx_fall_seen", tx_fall_q.size(), n);
    endtask

    task automatic wait_mon_idle();
        for (int i = 0; i < 3000 && mon_busy; i++) tick();
        check("tx_frame_end", {31'd0, mon_busy}, 0);
    endtask

    task automatic wait_rdrf();
        rs = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            #1;
            if (dout[0]) break;
            tick();
        end
    endtask

    // Line monitor. Each falling edge of tx starts a frame. Every cycle of
    // the frame is compared with the ideal 8N1 waveform of the queued byte,
    // and the byte is decoded at the mid-bit points.
    initial begin
        logic       prev;
        logic [7:0] eb;
        logic [7:0] dec;
        logic       ebit;
        int         errs;
        bit         ign;
        prev = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (prev === 1'b1 && tx === 1'b0) begin
                mon_busy = 1'b1;
                ign = mon_ignore;
                if (!ign) tx_fall_q.push_back(cyc);
                check("tx_expected", {31'd0, exp_tx_q.size() > 0}, 1);
                eb = (exp_tx_q.size() > 0) ? exp_tx_q.pop_front() : 8'h00;
                errs = 0;
                dec = 8'h00;
                for (int k = 0; k < FRAME; k++) begin
                    if (k > 0) begin
                        @(posedge clk);
                        #1;
                    end
                    if (k < CPB)                ebit = 1'b0;
                    else if (k >= 9 * CPB)      ebit = 1'b1;
                    else                        ebit = eb[k / CPB - 1];
                    if (tx !== ebit) errs++;
                    if ((k % CPB) == CPB / 2 && k >= CPB && k < 9 * CPB)
                        dec[k / CPB - 1] = tx;
                end
                if (!ign) begin
                    check("tx_byte", dec, eb);
                    check("tx_wave_errs", errs, 0);
                end
                prev = tx;
                mon_busy = 1'b0;
            end else begin
                prev = tx;
            end
        end
    end

    initial begin
        #2000000;
        $display("watchdog expired");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [7:0] d;
        int         n_cyc;
        int         f1, f2;

        repeat (3) tick();
        srst = 1'b0;
        tick();

        // Reset and master reset
        read_reg(1'b0, d);      check("reset_sr", d, 8'h00);
        check("reset_tx", tx, 1'b1);
        check("reset_irq", irq, 1'b0);
        write_reg(1'b0, 8'h95);
        read_reg(1'b0, d);      check("release_sr", d, 8'h02);
        check("release_irq", irq, 1'b0);
        write_reg(1'b0, 8'hB5);
        check("tie_irq", irq, 1'b1);
        read_reg(1'b0, d);      check("tie_sr", d, 8'h82);

        // Single transmit
        tx_fall_q.delete();
        exp_tx_q.push_back(8'hA5);
        write_reg(1'b1, 8'hA5);
        n_cyc = cyc;
        read_reg(1'b0, d);      check("tx_tdre_clr", d, 8'h00);
        read_reg(1'b0, d);      check("tx_tdre_set", d, 8'h82);
        wait_falls(1);
        f1 = tx_fall_q.pop_front();
        check("tx_start_edge", f1, n_cyc + 1);
        wait_mon_idle();

        // Back-to-back transmit
        tx_fall_q.delete();
        exp_tx_q.push_back(8'h12);
        write_reg(1'b1, 8'h12);
        repeat (1000) tick();
        exp_tx_q.push_back(8'h34);
        write_reg(1'b1, 8'h34);
        wait_falls(2);
        f1 = tx_fall_q.pop_front();
        f2 = tx_fall_q.pop_front();
        check("b2b_gap", f2 - f1, FRAME);
        wait_mon_idle();

        // Receive with RIE only
        write_reg(1'b0, 8'h95);
        read_reg(1'b0, d);      check("rx_idle_sr", d, 8'h02);
        exp_rx_q.push_back(8'h3C);
        send_rx(8'h3C, 1'b1);
        wait_rdrf();
        read_reg(1'b0, d);      check("rx_sr", d, 8'h83);
        check("rx_irq", irq, 1'b1);
        read_reg(1'b1, d);      check("rx_rdr", d, exp_rx_q.pop_front());
        read_reg(1'b0, d);      check("rx_sr_after_read", d, 8'h02);
        check("rx_irq_after_read", irq, 1'b0);

        // Overrun: second byte is lost
        exp_rx_q.push_back(8'h11);
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        read_reg(1'b0, d);      check("ovrn_sr", d, 8'hA3);
        read_reg(1'b1, d);      check("ovrn_rdr", d, exp_rx_q.pop_front());
        read_reg(1'b0, d);      check("ovrn_cleared", d, 8'h02);

        // Framing error
        exp_rx_q.push_back(8'h5A);
        send_rx(8'h5A, 1'b0);
        wait_rdrf();
        read_reg(1'b0, d);      check("fe_sr", d, 8'h93);
        read_reg(1'b1, d);      check("fe_rdr", d, exp_rx_q.pop_front());
        read_reg(1'b0, d);      check("fe_cleared", d, 8'h02);

        // Short low glitch must not produce a byte
        rx = 1'b0;
        repeat (100) tick();
        rx = 1'b1;
        repeat (3000) tick();
        read_reg(1'b0, d);      check("glitch_sr", d, 8'h02);

        // Abort a frame of all zeros with master reset
        mon_ignore = 1'b1;
        exp_tx_q.push_back(8'h00);
        write_reg(1'b1, 8'h00);
        repeat (1000) tick();
        write_reg(1'b0, 8'h03);
        tick();
        check("abort_tx", tx, 1'b1);
        check("abort_irq", irq, 1'b0);
        read_reg(1'b0, d);      check("abort_sr", d, 8'h00);
        repeat (2000) tick();
        wait_mon_idle();
        mon_ignore = 1'b0;

        // Full frame after release
        write_reg(1'b0, 8'h95);
        read_reg(1'b0, d);      check("rerelease_sr", d, 8'h02);
        tx_fall_q.delete();
        exp_tx_q.push_back(8'hC3);
        write_reg(1'b1, 8'hC3);
        wait_falls(1);
        wait_mon_idle();
        check("tx_q_drained", exp_tx_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
